// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window loader: DMA word layout,
// engine register map, packing geometry and the loader state encoding.
package conv_pkg;

  localparam int DMA_STB_BIT = 31;
  localparam int DMA_IDX_LSB = 24;
  localparam int DMA_DATA_W  = 24;

  localparam logic [2:0] PIX_BASE = 3'd0;
  localparam logic [2:0] KER_BASE = 3'd3;

  localparam logic [2:0] GROUPS_PER_CH   = 3'd6;
  localparam logic [1:0] BYTES_PER_GROUP = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    ACC,
    DONE
  } loader_state_e;

endpackage

// File: rtl/conv_byte_packer.sv
// Packs accepted bytes three at a time, first byte in the MSBs, and flags
// the cycle on which a group completes together with the packed word.
module conv_byte_packer
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic                  group_valid,
  output logic [DMA_DATA_W-1:0] group_word
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] pack_q, pack_d;

  // The completing byte is combined straight from the input so the group
  // is available on the same cycle it is accepted.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    pack_d      = pack_q;
    group_valid = 1'b0;
    group_word  = {pack_q, byte_in};
    if (accept) begin
      pack_d = {pack_q[7:0], byte_in};
      if (byte_cnt_q == BYTES_PER_GROUP - 2'd1) begin
        byte_cnt_d  = '0;
        group_valid = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
    end
  end

endmodule

// File: rtl/conv_window_loader.sv
// Byte-stream to 3x3 engine register loader with per-channel accumulate control.
// Optional CONV_WINDOW_LOADER_KERNEL_REUSE_EN adds reuse_kernel (pixel-only loads).
module conv_window_loader
  import conv_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int IDX_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CH_W-1:0] cfg_channels,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     dma_word,
  output logic            acc_clear,
  output logic            acc_enable,
  output logic            busy,
  output logic            done
`ifdef CONV_WINDOW_LOADER_KERNEL_REUSE_EN
  ,
  input  logic            reuse_kernel
`endif
);

  loader_state_e   state_q, state_d;
  logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [CH_W-1:0] ch_last_q, ch_last_d;
  logic [IDX_W-1:0] group_cnt_q, group_cnt_d;
  logic            reuse_q, reuse_d;
  logic [31:0]     dma_word_q, dma_word_d;
  logic            acc_clear_q, acc_clear_d;
  logic            acc_enable_q, acc_enable_d;
  logic            done_q, done_d;

  logic [IDX_W-1:0]      group_target;
  logic                  accept;
  logic                  group_valid;
  logic [DMA_DATA_W-1:0] group_word;

  // Kernel reuse stops the channel after the pixel registers.
  assign group_target = reuse_q ? IDX_W'(KER_BASE) : IDX_W'(GROUPS_PER_CH);
  assign in_ready     = (state_q == LOAD) && (group_cnt_q < group_target);
  assign accept       = in_valid && in_ready;

  conv_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .byte_in     (in_data),
    .group_valid (group_valid),
    .group_word  (group_word)
  );

  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    ch_last_d    = ch_last_q;
    group_cnt_d  = group_cnt_q;
    reuse_d      = reuse_q;
    dma_word_d   = {1'b0, dma_word_q[30:0]};
    acc_clear_d  = 1'b0;
    acc_enable_d = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ch_last_d   = (cfg_channels == '0) ? '0 : cfg_channels - CH_W'(1);
          ch_cnt_d    = '0;
          group_cnt_d = IDX_W'(PIX_BASE);
`ifdef CONV_WINDOW_LOADER_KERNEL_REUSE_EN
          reuse_d     = reuse_kernel && (cfg_channels <= CH_W'(1));
`else
          reuse_d     = 1'b0;
`endif
          acc_clear_d = 1'b1;
          state_d     = CLEAR;
        end
      end
      CLEAR: state_d = LOAD;
      LOAD: begin
        if (group_valid) begin
          dma_word_d = '0;
          dma_word_d[DMA_STB_BIT] = 1'b1;
          dma_word_d[DMA_IDX_LSB +: IDX_W] = group_cnt_q;
          dma_word_d[DMA_DATA_W-1:0] = group_word;
          group_cnt_d = group_cnt_q + IDX_W'(1);
        end
        // The last group's strobe is on the bus now; accumulate next cycle.
        if (dma_word_q[DMA_STB_BIT] && (group_cnt_q == group_target)) begin
          acc_enable_d = 1'b1;
          state_d      = ACC;
        end
      end
      ACC: begin
        if (ch_cnt_q == ch_last_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          ch_cnt_d    = ch_cnt_q + CH_W'(1);
          group_cnt_d = IDX_W'(PIX_BASE);
          state_d     = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_cnt_q     <= '0;
      ch_last_q    <= '0;
      group_cnt_q  <= '0;
      reuse_q      <= 1'b0;
      dma_word_q   <= '0;
      acc_clear_q  <= 1'b0;
      acc_enable_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      ch_last_q    <= ch_last_d;
      group_cnt_q  <= group_cnt_d;
      reuse_q      <= reuse_d;
      dma_word_q   <= dma_word_d;
      acc_clear_q  <= acc_clear_d;
      acc_enable_q <= acc_enable_d;
      done_q       <= done_d;
    end
  end

  assign dma_word   = dma_word_q;
  assign acc_clear  = acc_clear_q;
  assign acc_enable = acc_enable_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv_window_loader.sv
// Scoreboard bench for conv_window_loader with a behavioural 3x3 engine model
// driven from the loader's outputs.
module tb_conv_window_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_channels;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dma_word;
  logic        acc_clear;
  logic        acc_enable;
  logic        busy;
  logic        done;
`ifdef CONV_WINDOW_LOADER_KERNEL_REUSE_EN
  logic        reuse_kernel;
`endif

  conv_window_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_channels (cfg_channels),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dma_word     (dma_word),
    .acc_clear    (acc_clear),
    .acc_enable   (acc_enable),
    .busy         (busy),
    .done         (done)
`ifdef CONV_WINDOW_LOADER_KERNEL_REUSE_EN
    ,
    .reuse_kernel (reuse_kernel)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  bit          drv_en = 0;
  bit          gap_en = 0;
  bit          take   = 0;
  int          n_acc  = 0;

  int clr_cnt, en_cnt, done_cnt;
  int first_clr_cyc, first_stb_cyc, last_stb_cyc, en_cyc, done_cyc;
  int acc_model = 0;
  logic [23:0] eregs [6];

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int engine_dot();
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] p, w;
      int pi, wi;
      p  = eregs[k / 3][23 - 8 * (k % 3) -: 8];
      w  = eregs[3 + k / 3][23 - 8 * (k % 3) -: 8];
      pi = $signed(p);
      wi = $signed(w);
      s  = s + pi * wi;
    end
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Byte source: acceptance is observed mid-cycle, the byte is retired after the edge.
  always @(negedge clk) take = in_valid && in_ready && !rst;

  always @(posedge clk) begin
    #1;
    if (take && tx_q.size() > 0) begin
      void'(tx_q.pop_front());
      n_acc++;
    end
    if (drv_en && tx_q.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
      in_valid = 1'b1;
      in_data  = tx_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  end

  // Output monitor and engine model.
  always @(negedge clk) begin
    if (!rst) begin
      if (!busy || acc_clear || acc_enable || done)
        check_output("in_ready_low", {63'd0, in_ready}, 64'd0);
      if (dma_word[31]) begin
        last_stb_cyc = cyc;
        if (first_stb_cyc < 0) first_stb_cyc = cyc;
        if (exp_q.size() == 0)
          check_output("strobe_unexpected", {32'd0, dma_word}, 64'd0);
        else
          check_output("strobe", {32'd0, dma_word}, {32'd0, exp_q.pop_front()});
        if (dma_word[26:24] < 3'd6) eregs[dma_word[26:24]] = dma_word[23:0];
      end
      if (acc_clear) begin
        clr_cnt++;
        if (first_clr_cyc < 0) first_clr_cyc = cyc;
        acc_model = 0;
      end
      if (acc_enable) begin
        en_cnt++;
        en_cyc = cyc;
        acc_model = acc_model + engine_dot();
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic queue_group(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [2:0] idx);
    tx_q.push_back(b0);
    tx_q.push_back(b1);
    tx_q.push_back(b2);
    exp_q.push_back({1'b1, 4'd0, idx, b0, b1, b2});
  endtask

  task automatic queue_ramp();
    for (int g = 0; g < 6; g++)
      queue_group(8'(3 * g + 1), 8'(3 * g + 2), 8'(3 * g + 3), 3'(g));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_dma"}, {32'd0, dma_word}, 64'd0);
    check_output({tag, "_clear"}, {63'd0, acc_clear}, 64'd0);
    check_output({tag, "_enable"}, {63'd0, acc_enable}, 64'd0);
    check_output({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_output({tag, "_done"}, {63'd0, done}, 64'd0);
    check_output({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] ch, input bit reuse, input bit gaps,
                                input int exp_en, input int exp_acc, input int extra_at);
    int c0;
    clr_cnt = 0; en_cnt = 0; done_cnt = 0;
    first_clr_cyc = -1; first_stb_cyc = -1; last_stb_cyc = -1; en_cyc = -1; done_cyc = -1;
    gap_en = gaps;
    @(negedge clk); #1;
    start = 1'b1;
    cfg_channels = ch;
`ifdef CONV_WINDOW_LOADER_KERNEL_REUSE_EN
    reuse_kernel = reuse;
`endif
    drv_en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
      if (i == 0) start = 1'b0;
      if (extra_at >= 0 && i == extra_at) begin
        start = 1'b1;
        cfg_channels = 8'd5;
      end
      if (extra_at >= 0 && i == extra_at + 1) start = 1'b0;
    end
    check_output({tag, "_done_seen"}, {63'd0, done_cnt > 0}, 64'd1);
    repeat (4) begin
      @(negedge clk); #1;
    end
    drv_en = 1'b0;
    check_output({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_output({tag, "_clear_cnt"}, 64'(clr_cnt), 64'd1);
    check_output({tag, "_enable_cnt"}, 64'(en_cnt), 64'(exp_en));
    check_output({tag, "_engine_acc"}, 64'(acc_model), 64'(exp_acc));
    check_output({tag, "_strobes_left"}, 64'(exp_q.size()), 64'd0);
    check_output({tag, "_bytes_left"}, 64'(tx_q.size()), 64'd0);
    check_output({tag, "_clear_cyc"}, 64'(first_clr_cyc), 64'(c0 + 1));
    check_output({tag, "_enable_cyc"}, 64'(en_cyc), 64'(last_stb_cyc + 1));
    check_output({tag, "_done_cyc"}, 64'(done_cyc), 64'(en_cyc + 1));
    check_output({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    if (!gaps && !reuse && ch <= 8'd1) begin
      check_output({tag, "_first_strobe_lat"}, 64'(first_stb_cyc - c0), 64'd5);
      check_output({tag, "_done_lat"}, 64'(done_cyc - c0), 64'd22);
    end
    exp_q.delete();
    tx_q.delete();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    cfg_channels = 8'd0;
    in_valid = 1'b0;
    in_data = 8'd0;
`ifdef CONV_WINDOW_LOADER_KERNEL_REUSE_EN
    reuse_kernel = 1'b0;
`endif
    for (int r = 0; r < 6; r++) eregs[r] = 24'd0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    queue_ramp();
    apply_stimulus("ramp", 8'd1, 1'b0, 1'b0, 1, 690, -1);

    for (int c = 0; c < 3; c++) begin
      for (int g = 0; g < 3; g++) queue_group(8'h02, 8'h02, 8'h02, 3'(g));
      for (int g = 3; g < 6; g++) queue_group(8'hFF, 8'hFF, 8'hFF, 3'(g));
    end
    apply_stimulus("multi", 8'd3, 1'b0, 1'b0, 3, -54, -1);

    queue_ramp();
    apply_stimulus("gaps", 8'd1, 1'b0, 1'b1, 1, 690, -1);

    queue_ramp();
    apply_stimulus("busy_start", 8'd0, 1'b0, 1'b0, 1, 690, 4);

    // Abandon a pixel after ten bytes, then load a fresh one.
    queue_ramp();
    n_acc = 0;
    gap_en = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    cfg_channels = 8'd1;
    drv_en = 1'b1;
    for (int i = 0; i < 100 && n_acc < 10; i++) begin
      @(negedge clk); #1;
      start = 1'b0;
    end
    check_output("rst_bytes_before", 64'(n_acc), 64'd10);
    rst = 1'b1;
    drv_en = 1'b0;
    tx_q.delete();
    exp_q.delete();
    @(negedge clk); #1;
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    queue_ramp();
    apply_stimulus("after_rst", 8'd1, 1'b0, 1'b0, 1, 690, -1);

`ifdef CONV_WINDOW_LOADER_KERNEL_REUSE_EN
    for (int g = 0; g < 3; g++) queue_group(8'h01, 8'h01, 8'h01, 3'(g));
    for (int g = 3; g < 6; g++) queue_group(8'h02, 8'h02, 8'h02, 3'(g));
    apply_stimulus("kernel_full", 8'd1, 1'b0, 1'b0, 1, 18, -1);
    for (int g = 0; g < 3; g++)
      queue_group(8'(3 * g + 1), 8'(3 * g + 2), 8'(3 * g + 3), 3'(g));
    apply_stimulus("kernel_reuse", 8'd1, 1'b1, 1'b0, 1, 90, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
